// File: rtl/segment_scan_decoder.sv
// segment_scan_decoder
//
// Receive side of a multiplexed 7-segment display bus. It samples the active-low
// segment/select lines and rebuilds the BCD code shown on each digit. The block
// filters ghosting that appears while the scan moves between digits. It flags
// segment patterns it does not recognise, and it drops a digit's valid bit when
// that digit has not been refreshed for TIMEOUT_CYC cycles.
//
// Optional feature: define SEG_DP_EN to add decimal-point capture (dp_in / dp_out).
//
// Ports
//   clk          system clock, all logic on posedge
//   rst_n        asynchronous active-low reset
//   seg_in       segments {a,b,c,d,e,f,g}, active-low
//   sel_in       digit select, active-low one-hot, bit i = digit i
//   err_clr      synchronous clear of the sticky err bits
//   dp_in        (SEG_DP_EN only) active-low decimal point, sampled with seg_in
//   dp_out       (SEG_DP_EN only) 1 = decimal point lit on digit i
//   digits       decoded code per digit, digit i at [4i+3:4i]
//   digit_vld    digit i refreshed within TIMEOUT_CYC cycles
//   err          sticky, unknown pattern captured on digit i
//   upd_pulse    one-cycle pulse on every capture
//   frame_pulse  one-cycle pulse once every digit has been captured since the last frame
module segment_scan_decoder #(
    parameter int unsigned NUM_DIG     = 6,
    parameter int unsigned STABLE_CYC  = 4,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           seg_in,
    input  logic [NUM_DIG-1:0]   sel_in,
    input  logic                 err_clr,
`ifdef SEG_DP_EN
    input  logic                 dp_in,
    output logic [NUM_DIG-1:0]   dp_out,
`endif
    output logic [4*NUM_DIG-1:0] digits,
    output logic [NUM_DIG-1:0]   digit_vld,
    output logic [NUM_DIG-1:0]   err,
    output logic                 upd_pulse,
    output logic                 frame_pulse
);

    // Sample layout: {sel, [dp,] seg}; the dp bit sits at [7] when present.
`ifdef SEG_DP_EN
    localparam int unsigned SmpW = NUM_DIG + 8;
`else
    localparam int unsigned SmpW = NUM_DIG + 7;
`endif
    localparam int unsigned CntW = $clog2(STABLE_CYC + 1);
    localparam int unsigned AgeW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYC);
    localparam logic [AgeW-1:0] AgeMax = AgeW'(TIMEOUT_CYC);

    // Returns {unknown, code}.
    function automatic logic [4:0] decode(input logic [6:0] seg);
        logic [4:0] r;
        unique case (seg)
            7'b0000001: r = 5'h00;
            7'b1001111: r = 5'h01;
            7'b0010010: r = 5'h02;
            7'b0000110: r = 5'h03;
            7'b1001100: r = 5'h04;
            7'b0100100: r = 5'h05;
            7'b0100000: r = 5'h06;
            7'b0001111: r = 5'h07;
            7'b0000000: r = 5'h08;
            7'b0000100: r = 5'h09;
            7'b1111111: r = 5'h0F;
            default:    r = 5'h1E;
        endcase
        return r;
    endfunction

    logic [SmpW-1:0]              smp_in;
    logic [SmpW-1:0]              smp_s1_q, smp_s2_q, prev_q;
    logic [CntW-1:0]              cnt_q, cnt_d;
    logic [NUM_DIG-1:0][3:0]      digits_q, digits_d;
    logic [NUM_DIG-1:0][AgeW-1:0] age_q, age_d;
    logic [NUM_DIG-1:0]           vld_q, vld_d;
    logic [NUM_DIG-1:0]           err_q, err_d;
    logic [NUM_DIG-1:0]           seen_q, seen_d;
    logic                         upd_q, upd_d;
    logic                         frame_q, frame_d;
`ifdef SEG_DP_EN
    logic [NUM_DIG-1:0]           dp_q, dp_d;
`endif

    logic [NUM_DIG-1:0] sel_n;
    logic [NUM_DIG-1:0] cap_vec;
    logic [NUM_DIG-1:0] seen_nxt;
    logic               sel_ok;
    logic               same;
    logic               cap;
    logic [4:0]         dec;

`ifdef SEG_DP_EN
    assign smp_in = {sel_in, dp_in, seg_in};
`else
    assign smp_in = {sel_in, seg_in};
`endif

    always_comb begin
        sel_n  = ~smp_s2_q[SmpW-1 -: NUM_DIG];
        // Exactly one select line low: non-zero and a power of two.
        sel_ok = (sel_n != '0) && ((sel_n & (sel_n - (NUM_DIG)'(1))) == '0);
        same   = (smp_s2_q == prev_q);
        dec    = decode(smp_s2_q[6:0]);

        // The count saturates at CntMax so that a held sample cannot wrap and re-capture.
        if (!sel_ok) begin
            cnt_d = '0;
        end else if (same) begin
            cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
        end else begin
            cnt_d = CntW'(1);
        end

        // Fire on entry to CntMax only. The !same term covers STABLE_CYC == 1, where a
        // new sample reloads straight to CntMax.
        cap     = sel_ok && (cnt_d == CntMax) && !(same && (cnt_q == CntMax));
        cap_vec = cap ? sel_n : '0;

        digits_d = digits_q;
        vld_d    = vld_q;
        age_d    = age_q;
`ifdef SEG_DP_EN
        dp_d     = dp_q;
`endif
        for (int i = 0; i < int'(NUM_DIG); i++) begin
            if (cap_vec[i]) begin
                age_d[i] = '0;
            end else if (age_q[i] != AgeMax) begin
                age_d[i] = age_q[i] + AgeW'(1);
            end

            // A capture takes priority over a timeout in the same cycle.
            if (cap_vec[i]) begin
                digits_d[i] = dec[3:0];
                vld_d[i]    = 1'b1;
`ifdef SEG_DP_EN
                dp_d[i]     = ~smp_s2_q[7];
`endif
            end else if (age_d[i] == AgeMax) begin
                digits_d[i] = 4'hF;
                vld_d[i]    = 1'b0;
`ifdef SEG_DP_EN
                dp_d[i]     = 1'b0;
`endif
            end
        end

        // A new error sets its bit even when err_clr is asserted in the same cycle.
        err_d    = (err_clr ? '0 : err_q) | (dec[4] ? cap_vec : '0);

        seen_nxt = seen_q | cap_vec;
        frame_d  = &seen_nxt;
        seen_d   = frame_d ? '0 : seen_nxt;
        upd_d    = cap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp_s1_q <= '1;
            smp_s2_q <= '1;
            prev_q   <= '1;
            cnt_q    <= '0;
            digits_q <= '1;
            vld_q    <= '0;
            age_q    <= '0;
            err_q    <= '0;
            seen_q   <= '0;
            upd_q    <= 1'b0;
            frame_q  <= 1'b0;
`ifdef SEG_DP_EN
            dp_q     <= '0;
`endif
        end else begin
            smp_s1_q <= smp_in;
            smp_s2_q <= smp_s1_q;
            prev_q   <= smp_s2_q;
            cnt_q    <= cnt_d;
            digits_q <= digits_d;
            vld_q    <= vld_d;
            age_q    <= age_d;
            err_q    <= err_d;
            seen_q   <= seen_d;
            upd_q    <= upd_d;
            frame_q  <= frame_d;
`ifdef SEG_DP_EN
            dp_q     <= dp_d;
`endif
        end
    end

    assign digits      = digits_q;
    assign digit_vld   = vld_q;
    assign err         = err_q;
    assign upd_pulse   = upd_q;
    assign frame_pulse = frame_q;
`ifdef SEG_DP_EN
    assign dp_out      = dp_q;
`endif

endmodule

// File: tb/tb_segment_scan_decoder.sv
// Bench for segment_scan_decoder. Stimulus pushes the expected capture (digit, code,
// frame flag, arrival cycle) into a queue. A negedge monitor pops one entry for every
// upd_pulse it sees and compares the entry with the DUT outputs.
module tb_segment_scan_decoder;

    localparam int NUM_DIG = 6;
    localparam int STABLE  = 4;
    localparam int TMO     = 50;
    localparam int LAT     = STABLE + 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [6:0]           seg_in;
    logic [NUM_DIG-1:0]   sel_in;
    logic                 err_clr;
    logic [4*NUM_DIG-1:0] digits;
    logic [NUM_DIG-1:0]   digit_vld;
    logic [NUM_DIG-1:0]   err;
    logic                 upd_pulse;
    logic                 frame_pulse;
`ifdef SEG_DP_EN
    logic [NUM_DIG-1:0]   dp_out;
`endif

    segment_scan_decoder #(
        .NUM_DIG     (NUM_DIG),
        .STABLE_CYC  (STABLE),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .sel_in      (sel_in),
        .err_clr     (err_clr),
`ifdef SEG_DP_EN
        .dp_in       (1'b1),
        .dp_out      (dp_out),
`endif
        .digits      (digits),
        .digit_vld   (digit_vld),
        .err         (err),
        .upd_pulse   (upd_pulse),
        .frame_pulse (frame_pulse)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         idx;
        logic [3:0] val;
        bit         frame;
        int         cyc;
    } exp_t;

    exp_t             sb[$];
    exp_t             mon_e;
    int               n_cmp = 0;
    int               n_bad = 0;
    int               n_upd = 0;
    logic [NUM_DIG-1:0] tb_seen = '0;
    logic [6:0]       tab[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected capture of code val on digit idx, arriving at cycle c.
    task automatic push(input int idx, input logic [3:0] val, input int c);
        exp_t e;
        e.idx = idx;
        e.val = val;
        e.cyc = c;
        tb_seen[idx] = 1'b1;
        e.frame = (tb_seen == 6'h3F);
        if (e.frame) tb_seen = '0;
        sb.push_back(e);
    endtask

    // Returns #1 after posedge number n.
    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic [5:0] s, input logic [6:0] g);
        sel_in = s;
        seg_in = g;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        goto(cyc + 2);
        tb_seen = '0;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (upd_pulse) begin
                n_upd++;
                if (sb.size() == 0) begin
                    chk("unexpected upd_pulse", {63'd0, upd_pulse}, 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("capture latency", mon_e.cyc, cyc);
                    chk("captured code", {60'd0, digits[4*mon_e.idx +: 4]}, {60'd0, mon_e.val});
                    chk("captured vld", {63'd0, digit_vld[mon_e.idx]}, 64'd1);
                    chk("frame_pulse", {63'd0, frame_pulse}, {63'd0, mon_e.frame});
                end
            end else begin
                chk("stray frame_pulse", {63'd0, frame_pulse}, 64'd0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, k1, k2, n0;
        tab[0] = 7'b0000001; tab[1] = 7'b1001111; tab[2] = 7'b0010010;
        tab[3] = 7'b0000110; tab[4] = 7'b1001100; tab[5] = 7'b0100100;
        tab[6] = 7'b0100000; tab[7] = 7'b0001111; tab[8] = 7'b0000000;
        tab[9] = 7'b0000100;

        rst_n = 1'b0;
        err_clr = 1'b0;
        drive(6'h3F, 7'h7F);
        goto(3);
        chk("reset digits", {40'd0, digits}, 64'hFFFFFF);
        chk("reset vld", {58'd0, digit_vld}, 64'd0);
        chk("reset err", {58'd0, err}, 64'd0);
        chk("reset upd", {63'd0, upd_pulse}, 64'd0);
        chk("reset frame", {63'd0, frame_pulse}, 64'd0);
        rst_n = 1'b1;

        // Idle bus: nothing is captured.
        goto(cyc + 100);
        @(negedge clk);
        chk("idle digits", {40'd0, digits}, 64'hFFFFFF);
        chk("idle vld", {58'd0, digit_vld}, 64'd0);

        // Single digit 5 showing '2'.
        goto(cyc + 1);
        c = cyc;
        drive(6'b011111, tab[2]);
        push(5, 4'h2, c + LAT);
        goto(c + 10);
        drive(6'h3F, 7'h7F);
        @(negedge clk);
        chk("digit5 value", {60'd0, digits[23:20]}, 64'h2);
        chk("digit5 vld", {63'd0, digit_vld[5]}, 64'd1);

        do_reset();
        @(negedge clk);
        chk("mid-run reset digits", {40'd0, digits}, 64'hFFFFFF);

        // Full scan 0..5 showing 1..6; the frame completes on digit 5.
        goto(cyc + 1);
        for (int k = 0; k < NUM_DIG; k++) begin
            c = cyc;
            drive(~(6'd1 << k), tab[k + 1]);
            push(k, 4'(k + 1), c + LAT);
            goto(c + 8);
        end
        drive(6'h3F, 7'h7F);
        @(negedge clk);
        chk("scan digits", {40'd0, digits}, 64'h654321);
        chk("scan vld", {58'd0, digit_vld}, 64'h3F);

        // Glitch: held one cycle short of the stability count.
        goto(cyc + 1);
        n0 = n_upd;
        c = cyc;
        drive(6'b101111, tab[7]);
        goto(c + STABLE - 1);
        drive(6'h3F, 7'h7F);
        goto(cyc + 20);
        chk("glitch captures", n_upd - n0, 64'd0);

        // Unknown pattern on digit 0.
        c = cyc;
        drive(6'b111110, 7'b1000000);
        push(0, 4'hE, c + LAT);
        goto(c + 8);
        drive(6'h3F, 7'h7F);
        @(negedge clk);
        chk("error code", {60'd0, digits[3:0]}, 64'hE);
        chk("error flag", {58'd0, err}, 64'h01);

        // err_clr during a new error capture: the set wins.
        goto(cyc + 5);
        c = cyc;
        drive(6'b111110, 7'b1111110);
        push(0, 4'hE, c + LAT);
        goto(c + LAT - 1);
        err_clr = 1'b1;
        goto(c + LAT);
        err_clr = 1'b0;
        @(negedge clk);
        chk("err set beats clr", {58'd0, err}, 64'h01);
        goto(c + 8);
        drive(6'h3F, 7'h7F);
        err_clr = 1'b1;
        goto(cyc + 1);
        err_clr = 1'b0;
        @(negedge clk);
        chk("err_clr alone", {58'd0, err}, 64'd0);

        // Blank pattern on digit 1: code F, no error.
        goto(cyc + 1);
        c = cyc;
        drive(6'b111101, 7'b1111111);
        push(1, 4'hF, c + LAT);
        goto(c + 8);
        drive(6'h3F, 7'h7F);
        @(negedge clk);
        chk("blank no err", {58'd0, err}, 64'd0);
        chk("blank vld", {63'd0, digit_vld[1]}, 64'd1);

        // Timeout on digit 3.
        goto(cyc + 1);
        c = cyc;
        k1 = c + LAT;
        drive(6'b110111, tab[9]);
        push(3, 4'h9, k1);
        goto(c + 8);
        drive(6'h3F, 7'h7F);
        goto(k1 + TMO - 1);
        @(negedge clk);
        chk("vld before timeout", {63'd0, digit_vld[3]}, 64'd1);
        goto(k1 + TMO);
        @(negedge clk);
        chk("vld after timeout", {63'd0, digit_vld[3]}, 64'd0);
        chk("digit after timeout", {60'd0, digits[15:12]}, 64'hF);

        // Refresh landing exactly on the timeout cycle keeps the digit valid.
        goto(cyc + 1);
        c = cyc;
        k2 = c + LAT;
        drive(6'b110111, tab[5]);
        push(3, 4'h5, k2);
        goto(c + 8);
        drive(6'h3F, 7'h7F);
        goto(k2 + TMO - LAT);
        drive(6'b110111, tab[8]);
        push(3, 4'h8, k2 + TMO);
        for (int t = TMO - 1; t <= TMO + 1; t++) begin
            goto(k2 + t);
            @(negedge clk);
            chk("vld across refresh", {63'd0, digit_vld[3]}, 64'd1);
        end
        chk("refreshed digit", {60'd0, digits[15:12]}, 64'h8);
        goto(k2 + TMO + 2);
        drive(6'h3F, 7'h7F);

        goto(cyc + 10);
        chk("scoreboard drained", sb.size(), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
